// File: rtl/latency_ping_scheduler_if.sv
// latency_ping_scheduler_if: control, measurement and readout signals of the latency ping scheduler
interface latency_ping_scheduler_if #(
  parameter int NUM_LINKS = 4,
  parameter int SELW = $clog2(NUM_LINKS)
);
  logic runEnable;
  logic [NUM_LINKS-1:0] linkEnable;
  logic [NUM_LINKS-1:0] linkRxValid;
  logic [31:0] latencyIn;
  logic [SELW-1:0] linkSelect;
  logic ping;
  logic [SELW-1:0] readIndex;
  logic [31:0] readLatency;
  logic readValid;
  logic measureStrobe;
  logic busy;
  logic [15:0] roundCount;
  modport master (
    output runEnable, linkEnable, linkRxValid, latencyIn, readIndex,
    input linkSelect, ping, readLatency, readValid, measureStrobe, busy, roundCount
  );
  modport slave (
    input runEnable, linkEnable, linkRxValid, latencyIn, readIndex,
    output linkSelect, ping, readLatency, readValid, measureStrobe, busy, roundCount
  );
endinterface

// File: rtl/latency_ping_scheduler.sv
// latency_ping_scheduler: round-robin sequencer sharing one latency-measurement unit across links
module latency_ping_scheduler #(
  parameter int NUM_LINKS = 4,
  parameter int SETTLE_TICKS = 16,
  parameter int PING_TICKS = 4,
  parameter int WAIT_TICKS = 400,
  parameter int INTERVAL_TICKS = 100000,
  parameter int SELW = $clog2(NUM_LINKS)
) (
  input logic sysClk,
  input logic sysReset_n,
  latency_ping_scheduler_if.slave bus
);
  localparam int SW = $clog2(SETTLE_TICKS) + 1;
  localparam int PW = $clog2(PING_TICKS) + 1;
  localparam int WW = $clog2(WAIT_TICKS) + 1;
  localparam int CW = SW > PW ? (SW > WW ? SW : WW) : (PW > WW ? PW : WW);
  localparam int IW = $clog2(INTERVAL_TICKS) + 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_TICKS - 1);
  localparam logic [CW-1:0] PING_LD = CW'(PING_TICKS - 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_TICKS - 1);
  localparam logic [IW-1:0] INTERVAL_LD = IW'(INTERVAL_TICKS - 1);
  localparam logic [SELW-1:0] LAST = SELW'(NUM_LINKS - 1);

  typedef enum logic [2:0] {IDLE, SCAN, SELECT, PING, WAIT, CAPTURE, DONE} state_t;
  state_t state, nextState;
  logic [SELW-1:0] cand;
  logic [CW-1:0] phaseCnt;
  logic [IW-1:0] timer;
  logic pending;
  logic [31:0] latTable [NUM_LINKS];
  logic [NUM_LINKS-1:0] validFlags;
  logic [31:0] readTab [2**SELW];
  logic [2**SELW-1:0] validView;
  logic timerZero, start, measurable, selOk, abort, phaseEnd, lastOrStop;

  // zero-padded view so out-of-range read addresses return 0/0
  for (genvar g = 0; g < 2**SELW; g++) begin : gView
    if (g < NUM_LINKS) begin : gReal
      assign readTab[g] = latTable[g];
      assign validView[g] = validFlags[g];
    end else begin : gPad
      assign readTab[g] = '0;
      assign validView[g] = 1'b0;
    end
  end

  // next-state: a selected link dropping out mid-measurement aborts to the next candidate
  always_comb begin
    timerZero = timer == '0;
    start = state == IDLE && bus.runEnable && (pending || timerZero);
    measurable = bus.linkEnable[cand] && bus.linkRxValid[cand];
    selOk = bus.linkEnable[bus.linkSelect] && bus.linkRxValid[bus.linkSelect];
    abort = state inside {SELECT, PING, WAIT} && !selOk;
    phaseEnd = phaseCnt == '0;
    lastOrStop = cand == LAST || !bus.runEnable;
    nextState = state;
    case (state)
      IDLE: nextState = start ? SCAN : IDLE;
      SCAN: nextState = !bus.runEnable ? DONE : measurable ? SELECT : cand == LAST ? DONE : SCAN;
      SELECT: nextState = phaseEnd ? PING : SELECT;
      PING: nextState = phaseEnd ? WAIT : PING;
      WAIT: nextState = phaseEnd ? CAPTURE : WAIT;
      CAPTURE: nextState = lastOrStop ? DONE : SCAN;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (abort) nextState = lastOrStop ? DONE : SCAN;
  end

  // state register, candidate cursor and per-phase tick counter
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state <= IDLE;
      cand <= '0;
      phaseCnt <= '0;
    end else begin
      state <= nextState;
      cand <= state == IDLE ? '0 : nextState == SCAN ? cand + 1'b1 : cand;
      phaseCnt <= nextState == state ? phaseCnt - 1'b1 :
                  nextState == SELECT ? SETTLE_LD : nextState == PING ? PING_LD : WAIT_LD;
    end
  end

  // free-running interval timer; each expiry arms a single pending start
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      timer <= INTERVAL_LD;
      pending <= 1'b0;
    end else begin
      timer <= timerZero ? INTERVAL_LD : timer - 1'b1;
      pending <= (pending || timerZero) && !start;
    end
  end

  // link select latch and latency table: capture stores, skips and aborts invalidate
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      bus.linkSelect <= '0;
      latTable <= '{default: '0};
      validFlags <= '0;
    end else begin
      if (state == SCAN && nextState == SELECT) bus.linkSelect <= cand;
      if (state == SCAN && bus.runEnable && bus.linkEnable[cand] && !bus.linkRxValid[cand]) validFlags[cand] <= 1'b0;
      if (abort) validFlags[bus.linkSelect] <= 1'b0;
      if (state == CAPTURE) begin
        latTable[bus.linkSelect] <= bus.latencyIn;
        validFlags[bus.linkSelect] <= 1'b1;
      end
    end
  end

  // registered read port and status outputs aligned with the state they describe
  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      bus.readLatency <= '0;
      bus.readValid <= 1'b0;
      bus.ping <= 1'b0;
      bus.measureStrobe <= 1'b0;
      bus.busy <= 1'b0;
      bus.roundCount <= '0;
    end else begin
      bus.readLatency <= readTab[bus.readIndex];
      bus.readValid <= validView[bus.readIndex];
      bus.ping <= nextState == PING;
      bus.measureStrobe <= nextState == CAPTURE;
      bus.busy <= nextState != IDLE;
      if (state == DONE) bus.roundCount <= bus.roundCount + 1'b1;
    end
  end
endmodule

// File: doc/latency_ping_scheduler.md
Name: latency_ping_scheduler

Overview:
- Time-shares one latency-measurement unit among NUM_LINKS fiber links.
- Sequences mux select, settle, ping pulse, echo wait and result capture per link, round-robin, once per measurement interval.
- Keeps a per-link latency table for the register readout.
- Sits in the sysClk domain between the link mux, the measurement unit's ping input and its 32-bit latency word.

Parameters:
NUM_LINKS, 4, number of links sharing the measurement unit (2..16)
SETTLE_TICKS, 16, sysClk cycles after changing linkSelect before ping (mux/sync settle)
PING_TICKS, 4, sysClk cycles ping is held high (must span several sampling clocks)
WAIT_TICKS, 400, sysClk cycles after ping falls before capture (covers 2 us limit plus CDC)
INTERVAL_TICKS, 100000, sysClk cycles between round starts
SELW, $clog2(NUM_LINKS), width of link index ports

Ports:
sysClk  in  1  system clock
sysReset_n  in  1  asynchronous active-low reset
runEnable  in  1  level; allows rounds to start
linkEnable  in  NUM_LINKS  per-link measurement enable
linkRxValid  in  NUM_LINKS  per-link receiver-locked status (sysClk-synchronous)
latencyIn  in  32  latency word from the shared measurement unit
linkSelect  out  SELW  mux select to the measurement unit
ping  out  1  ping request to the measurement unit
readIndex  in  SELW  table read address
readLatency  out  32  stored latency for readIndex, 1-cycle registered
readValid  out  1  valid flag for readIndex, 1-cycle registered
measureStrobe  out  1  one-cycle pulse on each successful capture
busy  out  1  high while a round is in progress
roundCount  out  16  completed-round counter, wraps at 0xFFFF to 0

Behaviour:
- Reset state: all outputs 0, table words 0, valid flags 0, state IDLE, interval timer loaded with INTERVAL_TICKS-1.
- Interval timer:
  - Free-running down-counter; reloads on reaching 0 and sets a pending flag.
  - A round starts in IDLE when pending and runEnable are both high; starting clears pending.
  - Pending never stacks: a round longer than the interval causes exactly one immediate restart.
- State machine: IDLE -> SCAN -> SELECT -> PING -> WAIT -> CAPTURE -> SCAN ... -> DONE -> IDLE.
- SCAN:
  - Candidate index starts at 0 each round and moves 0..NUM_LINKS-1 ascending, one candidate per cycle.
  - Disabled links (linkEnable low) are skipped and their valid flag is unchanged.
  - Enabled links with linkRxValid low are skipped and their valid flag is cleared.
  - When the candidate is enabled with linkRxValid high, latch linkSelect and go to SELECT.
  - After the last candidate, go to DONE.
- SELECT: SETTLE_TICKS cycles, ping low.
- PING: PING_TICKS cycles, ping high. ping is registered and high only in PING.
- WAIT: WAIT_TICKS cycles, ping low.
- CAPTURE: 1 cycle.
  - Write latencyIn to the table entry, set its valid flag, pulse measureStrobe.
  - Return to SCAN with the next candidate.
- Abort: if linkEnable or linkRxValid of the selected link falls during SELECT/PING/WAIT:
  - ping drops next cycle.
  - Valid flag cleared, table word unchanged, no strobe.
  - Continue SCAN with the next link.
- DONE: 1 cycle; roundCount increments. Also reached with zero measurable links; roundCount still increments.
- busy is high in every state except IDLE.
- runEnable low mid-round: the current link completes, including capture. Then go directly to DONE and IDLE; no further links are measured.
- linkSelect holds its last value in IDLE.
- Read port:
  - Registered readLatency/readValid reflect the table at the previous cycle's readIndex.
  - Read of the entry being written in CAPTURE returns the old value that cycle and the new value the next.
  - readIndex >= NUM_LINKS returns 0/0.
- Counter widths: $clog2 of each tick parameter plus 1. All tick parameters must be >= 1.

Test Plan:
1. NUM_LINKS=4, SETTLE=2, PING=3, WAIT=10, INTERVAL=200, all enabled/valid, latencyIn=0x0123_4567 -> linkSelect 0,1,2,3; ping high 3 cycles each; 4 strobes; busy for 4*(1+2+3+10+1)+1 cycles; roundCount=1; readLatency(2)=0x0123_4567, readValid=1.
2. linkEnable=4'b1010 -> only links 1,3 pinged, 2 strobes; valid flags for 0,2 unchanged from reset (0).
3. Drop linkRxValid[1] during WAIT of link 1 -> ping already low, no strobe for 1, readValid(1)=0, prior word retained, link 2 then measured.
4. Deassert runEnable during PING of link 0 -> link 0 captured, then DONE, roundCount+1, no further round until runEnable returns and the timer expires.
5. INTERVAL=20 (shorter than a round) -> next round starts on the cycle after DONE; exactly one extra round, no backlog.
6. Assert sysReset_n low mid-PING -> ping, busy, table, roundCount all 0 immediately; first round starts INTERVAL cycles after release.
